// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text console writer: geometry defaults,
// control-character codes, writer FSM states and cursor commands.
package vga_text_pkg;

   // Default screen geometry (1280x720 with 8x8 glyphs)
   localparam int DEF_COLS       = 160;
   localparam int DEF_ROWS       = 90;
   localparam int DEF_ROW_STRIDE = 1280;
   localparam int DEF_ADDR_W     = 32;

   // Character codes the writer interprets
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_FF    = 8'h0C;

   // Writer FSM states; CLEAR_ALL is the reset state
   typedef enum logic [1:0] {
      ST_CLEAR_ALL       = 2'd0,
      ST_IDLE            = 2'd1,
      ST_CHAR_THEN_CLEAR = 2'd2,
      ST_CLEAR_ROW       = 2'd3
   } writer_state_t;

   // Commands understood by the cursor block
   typedef enum logic [2:0] {
      CUR_NONE    = 3'd0,
      CUR_ADVANCE = 3'd1,   // col+1, wraps onto a new row at the last column
      CUR_NEWLINE = 3'd2,   // col=0 and advance row
      CUR_RETURN  = 3'd3,   // col=0 only
      CUR_BACK    = 3'd4,   // col-1 when col>0
      CUR_HOME    = 3'd5    // back to (0,0)
   } cursor_cmd_t;

   // True for bytes that are written to the screen as glyphs
   function automatic logic is_printable(input logic [7:0] ch);
      return (ch >= CH_SPACE) && (ch <= CH_TILDE);
   endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position tracker. Keeps column, row and the address of the start
// of the current row, so the writer never needs a multiplier: the row base
// steps by ROW_STRIDE on each row advance and returns to zero on wrap.
module console_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS       = DEF_COLS,
   parameter int ROWS       = DEF_ROWS,
   parameter int ROW_STRIDE = DEF_ROW_STRIDE,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int COL_W      = $clog2(COLS),
   parameter int ROW_W      = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  cursor_cmd_t       cmd,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [ADDR_W-1:0] row_base,
   output logic              at_last_col
);

   logic [COL_W-1:0]  col_reg,  col_next;
   logic [ROW_W-1:0]  row_reg,  row_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              advance_row;

   assign col         = col_reg;
   assign row         = row_reg;
   assign row_base    = base_reg;
   assign at_last_col = (col_reg == COL_W'(COLS - 1));

   // Next cursor position from the current command; row advance wraps to
   // the top of the screen (no scrolling).
   always_comb begin
      col_next    = col_reg;
      row_next    = row_reg;
      base_next   = base_reg;
      advance_row = 1'b0;

      case (cmd)
         CUR_ADVANCE: begin
            if (at_last_col) begin
               col_next    = '0;
               advance_row = 1'b1;
            end else begin
               col_next = col_reg + COL_W'(1);
            end
         end
         CUR_NEWLINE: begin
            col_next    = '0;
            advance_row = 1'b1;
         end
         CUR_RETURN: begin
            col_next = '0;
         end
         CUR_BACK: begin
            if (col_reg != '0) begin
               col_next = col_reg - COL_W'(1);
            end
         end
         CUR_HOME: begin
            col_next  = '0;
            row_next  = '0;
            base_next = '0;
         end
         default: ;
      endcase

      if (advance_row) begin
         if (row_reg == ROW_W'(ROWS - 1)) begin
            row_next  = '0;
            base_next = '0;
         end else begin
            row_next  = row_reg + ROW_W'(1);
            base_next = base_reg + ADDR_W'(ROW_STRIDE);
         end
      end
   end

   // Cursor registers; reset homes the cursor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg  <= '0;
         row_reg  <= '0;
         base_reg <= '0;
      end else begin
         col_reg  <= col_next;
         row_reg  <= row_next;
         base_reg <= base_next;
      end
   end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: consumes an ASCII byte stream and writes glyph codes
// into the text character memory at row*ROW_STRIDE + col. Control codes
// move the cursor; new rows and form feeds are blanked with spaces by
// hardware clear sequences, during which input is stalled.
module text_console_writer
   import vga_text_pkg::*;
#(
   parameter int COLS       = DEF_COLS,
   parameter int ROWS       = DEF_ROWS,
   parameter int ROW_STRIDE = DEF_ROW_STRIDE,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [7:0]               in_char,
   output logic                     in_ready,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_din,
   output logic                     mem_we,
   output logic [$clog2(COLS)-1:0]  cursor_col,
   output logic [$clog2(ROWS)-1:0]  cursor_row,
   output logic                     busy
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);

   writer_state_t     state_reg, state_next;

   // Clear-sequence counters; both clears share the column counter. All
   // counters return to zero when a clear finishes, so every clear starts
   // from the first cell without extra initialisation.
   logic [COL_W-1:0]  clr_col_reg,  clr_col_next;
   logic [ROW_W-1:0]  clr_row_reg,  clr_row_next;
   logic [ADDR_W-1:0] clr_base_reg, clr_base_next;

   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [7:0]        mem_din_reg,  mem_din_next;
   logic              mem_we_reg,   mem_we_next;
   logic              busy_reg;

   cursor_cmd_t       cur_cmd;
   logic [COL_W-1:0]  cur_col;
   logic [ROW_W-1:0]  cur_row;
   logic [ADDR_W-1:0] cur_base;
   logic              cur_last;
   logic [ADDR_W-1:0] cur_addr;

   console_cursor #(
      .COLS       (COLS),
      .ROWS       (ROWS),
      .ROW_STRIDE (ROW_STRIDE),
      .ADDR_W     (ADDR_W),
      .COL_W      (COL_W),
      .ROW_W      (ROW_W)
   ) u_cursor (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cur_cmd),
      .col         (cur_col),
      .row         (cur_row),
      .row_base    (cur_base),
      .at_last_col (cur_last)
   );

   assign cur_addr   = cur_base + ADDR_W'(cur_col);
   assign in_ready   = (state_reg == ST_IDLE);
   assign mem_addr   = mem_addr_reg;
   assign mem_din    = mem_din_reg;
   assign mem_we     = mem_we_reg;
   assign cursor_col = cur_col;
   assign cursor_row = cur_row;
   assign busy       = busy_reg;

   // Next state, next memory write and cursor command. In IDLE a byte is
   // consumed whenever in_valid is high (in_ready is high by definition).
   // After a row advance the cursor already points at the new row, so the
   // row clear addresses come straight from its row base.
   always_comb begin
      state_next    = state_reg;
      clr_col_next  = clr_col_reg;
      clr_row_next  = clr_row_reg;
      clr_base_next = clr_base_reg;
      mem_addr_next = mem_addr_reg;
      mem_din_next  = mem_din_reg;
      mem_we_next   = 1'b0;
      cur_cmd       = CUR_NONE;

      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_printable(in_char)) begin
                  mem_we_next   = 1'b1;
                  mem_addr_next = cur_addr;
                  mem_din_next  = in_char;
                  cur_cmd       = CUR_ADVANCE;
                  if (cur_last) begin
                     state_next = ST_CHAR_THEN_CLEAR;
                  end
               end else begin
                  case (in_char)
                     CH_LF: begin
                        cur_cmd    = CUR_NEWLINE;
                        state_next = ST_CLEAR_ROW;
                     end
                     CH_CR: begin
                        cur_cmd = CUR_RETURN;
                     end
                     CH_BS: begin
                        if (cur_col != '0) begin
                           mem_we_next   = 1'b1;
                           mem_addr_next = cur_addr - ADDR_W'(1);
                           mem_din_next  = CH_SPACE;
                           cur_cmd       = CUR_BACK;
                        end
                     end
                     CH_FF: begin
                        cur_cmd    = CUR_HOME;
                        state_next = ST_CLEAR_ALL;
                     end
                     default: ;   // unsupported byte: consumed, ignored
                  endcase
               end
            end
         end

         ST_CHAR_THEN_CLEAR, ST_CLEAR_ROW: begin
            mem_we_next   = 1'b1;
            mem_addr_next = cur_base + ADDR_W'(clr_col_reg);
            mem_din_next  = CH_SPACE;
            if (clr_col_reg == COL_W'(COLS - 1)) begin
               clr_col_next = '0;
               state_next   = ST_IDLE;
            end else begin
               clr_col_next = clr_col_reg + COL_W'(1);
            end
         end

         ST_CLEAR_ALL: begin
            mem_we_next   = 1'b1;
            mem_addr_next = clr_base_reg + ADDR_W'(clr_col_reg);
            mem_din_next  = CH_SPACE;
            if (clr_col_reg == COL_W'(COLS - 1)) begin
               clr_col_next = '0;
               if (clr_row_reg == ROW_W'(ROWS - 1)) begin
                  clr_row_next  = '0;
                  clr_base_next = '0;
                  state_next    = ST_IDLE;
               end else begin
                  clr_row_next  = clr_row_reg + ROW_W'(1);
                  clr_base_next = clr_base_reg + ADDR_W'(ROW_STRIDE);
               end
            end else begin
               clr_col_next = clr_col_reg + COL_W'(1);
            end
         end

         default: begin
            state_next = ST_CLEAR_ALL;
         end
      endcase
   end

   // State, counters and registered memory-port outputs; reset aborts any
   // operation and restarts with a full-screen clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_CLEAR_ALL;
         clr_col_reg  <= '0;
         clr_row_reg  <= '0;
         clr_base_reg <= '0;
         mem_addr_reg <= '0;
         mem_din_reg  <= CH_SPACE;
         mem_we_reg   <= 1'b0;
         busy_reg     <= 1'b1;
      end else begin
         state_reg    <= state_next;
         clr_col_reg  <= clr_col_next;
         clr_row_reg  <= clr_row_next;
         clr_base_reg <= clr_base_next;
         mem_addr_reg <= mem_addr_next;
         mem_din_reg  <= mem_din_next;
         mem_we_reg   <= mem_we_next;
         busy_reg     <= (state_next != ST_IDLE);
      end
   end

endmodule
